// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control symbols, lane-alignment FSM states and geometry
// constants, reused by the word aligner and the TMDS decoder.
package tmds_pkg;

    localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

    localparam int         SYM_W      = 10;
    localparam int         HIST_W     = 2 * SYM_W;
    localparam logic [2:0] PH_LAST    = 3'd4;
    localparam logic [3:0] OFFSET_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_CHECK,
        ST_LOCKED
    } align_state_t;

    function automatic logic is_tmds_ctrl(input logic [SYM_W-1:0] w);
        return (w == TMDS_CTRL_00) || (w == TMDS_CTRL_01) ||
               (w == TMDS_CTRL_10) || (w == TMDS_CTRL_11);
    endfunction

endpackage

// File: rtl/tmds_bit_window.sv
// 20-bit DDR history with a 0..9 barrel select and the mod-5 phase counter that
// marks the edge on which a complete symbol window is available.
module tmds_bit_window
    import tmds_pkg::*;
(
    input  logic             clk_shift,
    input  logic             rst_n,
    input  logic [1:0]       q,
    input  logic [3:0]       offset,
    output logic [SYM_W-1:0] win,
    output logic             emit
);

    logic [HIST_W-1:0] hist;
    logic [HIST_W-1:0] hist_next;
    logic [HIST_W-1:0] shifted;
    logic [2:0]        ph;

    // The pair arriving on this edge is already part of the selected window.
    assign hist_next = {q, hist[HIST_W-1:2]};
    assign emit      = (ph == PH_LAST);
    assign shifted   = hist_next >> offset;
    assign win       = shifted[SYM_W-1:0];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order of always blocks.
    always_ff @(posedge clk_shift or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            ph   <= '0;
        end else begin
            hist <= hist_next;
            ph   <= emit ? 3'd0 : ph + 3'd1;
        end
    end

endmodule

// File: rtl/tmds_word_aligner.sv
// Per-lane TMDS symbol aligner: bit-slips the window until a run of control symbols
// is seen, then emits aligned words with a strobe every fifth shift clock.
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN     = 8,
    parameter int SLIP_TIMEOUT = 4096,
    parameter int LOSS_WORDS   = 8192
) (
    input  logic             clk_shift,
    input  logic             rst_n,
    input  logic [1:0]       q,
    output logic [SYM_W-1:0] word,
    output logic             word_valid,
    output logic             ctrl,
    output logic             locked,
    output logic [3:0]       offset
);

    localparam int RUN_W  = $clog2(CTRL_RUN + 1);
    localparam int MISS_W = $clog2(SLIP_TIMEOUT + 1);
    localparam int LOSS_W = $clog2(LOSS_WORDS + 1);

    logic [SYM_W-1:0] win;
    logic             emit;
    logic             is_ctrl;

    align_state_t      state, state_n;
    logic [RUN_W-1:0]  run,  run_n,  run_inc;
    logic [MISS_W-1:0] miss, miss_n, miss_inc;
    logic [LOSS_W-1:0] loss, loss_n, loss_inc;
    logic [3:0]        offset_n;

    tmds_bit_window u_window (
        .clk_shift (clk_shift),
        .rst_n     (rst_n),
        .q         (q),
        .offset    (offset),
        .win       (win),
        .emit      (emit)
    );

    assign is_ctrl  = is_tmds_ctrl(win);
    assign run_inc  = run + 1'b1;
    assign miss_inc = miss + 1'b1;
    assign loss_inc = loss + 1'b1;

    always_ff @(posedge clk_shift or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_SEARCH;
            run    <= '0;
            miss   <= '0;
            loss   <= '0;
            offset <= '0;
        end else begin
            state  <= state_n;
            run    <= run_n;
            miss   <= miss_n;
            loss   <= loss_n;
            offset <= offset_n;
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_n  = state;
        run_n    = run;
        miss_n   = miss;
        loss_n   = loss;
        offset_n = offset;
        if (emit) begin
            unique case (state)
                ST_SEARCH: begin
                    if (is_ctrl) begin
                        miss_n = '0;
                        if (CTRL_RUN == 1) begin
                            state_n = ST_LOCKED;
                            run_n   = '0;
                            loss_n  = '0;
                        end else begin
                            state_n = ST_CHECK;
                            run_n   = RUN_W'(1);
                        end
                    end else if (miss_inc == MISS_W'(SLIP_TIMEOUT)) begin
                        miss_n   = '0;
                        offset_n = (offset == OFFSET_MAX) ? 4'd0 : offset + 4'd1;
                    end else begin
                        miss_n = miss_inc;
                    end
                end
                ST_CHECK: begin
                    if (!is_ctrl) begin
                        state_n = ST_SEARCH;
                        run_n   = '0;
                    end else if (run_inc == RUN_W'(CTRL_RUN)) begin
                        state_n = ST_LOCKED;
                        run_n   = '0;
                        loss_n  = '0;
                    end else begin
                        run_n = run_inc;
                    end
                end
                ST_LOCKED: begin
                    // A completed run refreshes the loss window even on its expiry word.
                    if (is_ctrl && run_inc == RUN_W'(CTRL_RUN)) begin
                        run_n  = '0;
                        loss_n = '0;
                    end else begin
                        run_n = is_ctrl ? run_inc : '0;
                        if (loss_inc == LOSS_W'(LOSS_WORDS)) begin
                            state_n = ST_SEARCH;
                            run_n   = '0;
                            miss_n  = '0;
                            loss_n  = '0;
                        end else begin
                            loss_n = loss_inc;
                        end
                    end
                end
                default: state_n = ST_SEARCH;
            endcase
        end
    end

    always_comb begin
        locked = (state == ST_LOCKED);
    end

    always_ff @(posedge clk_shift or negedge rst_n) begin
        if (!rst_n) begin
            word       <= '0;
            word_valid <= 1'b0;
            ctrl       <= 1'b0;
        end else begin
            word_valid <= emit;
            if (emit) begin
                word <= win;
                ctrl <= is_ctrl;
            end
        end
    end

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner: bit-serial symbol stream, alignment, slip,
// false start, loss of lock and asynchronous reset.
module tb_tmds_word_aligner;

    logic       clk_shift = 1'b0;
    logic       rst_n     = 1'b0;
    logic [1:0] q         = 2'b00;
    logic [9:0] word;
    logic       word_valid;
    logic       ctrl;
    logic       locked;
    logic [3:0] offset;

    int n_vec = 0;
    int n_err = 0;

    bit         bq[$];
    logic [9:0] sent[$];

    localparam logic [9:0] DATA_SYM = 10'h1C7;

    tmds_word_aligner #(
        .CTRL_RUN     (8),
        .SLIP_TIMEOUT (64),
        .LOSS_WORDS   (32)
    ) dut (
        .clk_shift  (clk_shift),
        .rst_n      (rst_n),
        .q          (q),
        .word       (word),
        .word_valid (word_valid),
        .ctrl       (ctrl),
        .locked     (locked),
        .offset     (offset)
    );

    always #5 clk_shift = ~clk_shift;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ctrl(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    function automatic logic [9:0] line_sym(input int j);
        if ((j % 64) < 16) return ((j % 2) == 0) ? 10'h354 : 10'h0AB;
        return DATA_SYM;
    endfunction

    // Drive the next two stream bits (earliest in q[0]) and land 1 time unit past the edge.
    task automatic step();
        bit b0, b1;
        b0 = (bq.size() > 0) ? bq.pop_front() : 1'b0;
        b1 = (bq.size() > 0) ? bq.pop_front() : 1'b0;
        q  = {b1, b0};
        @(posedge clk_shift);
        #1;
    endtask

    // One symbol period; the word emitted at its end is the previously queued symbol
    // at offset 0, because the first window after reset is reset-filled history.
    task automatic emit_call(input logic [9:0] sym);
        for (int i = 0; i < 10; i++) bq.push_back(sym[i]);
        sent.push_back(sym);
        repeat (5) step();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        bq.delete();
        sent.delete();
        #4 rst_n = 1'b1;
    endtask

    initial begin
        int n;

        // Reset values.
        #1;
        check("rst_word",   word,               10'h000);
        check("rst_valid",  10'(word_valid),    10'd0);
        check("rst_ctrl",   10'(ctrl),          10'd0);
        check("rst_locked", 10'(locked),        10'd0);
        check("rst_offset", 10'(offset),        10'd0);

        // First strobe on the 5th edge after release, then exactly 1 in 5.
        @(posedge clk_shift);
        #2 rst_n = 1'b1;
        repeat (4) step();
        check("strobe_edge4", 10'(word_valid), 10'd0);
        step();
        check("strobe_edge5", 10'(word_valid), 10'd1);
        step();
        check("strobe_edge6", 10'(word_valid), 10'd0);
        repeat (3) step();
        check("strobe_edge9", 10'(word_valid), 10'd0);
        step();
        check("strobe_edge10", 10'(word_valid), 10'd1);

        // Continuous 0x354 at offset 0.
        do_reset();
        for (n = 1; n <= 9; n++) begin
            emit_call(10'h354);
            if (n == 1) check("c354_first_word", word, 10'h000);
            if (n == 8) check("c354_locked_w7", 10'(locked), 10'd0);
        end
        check("c354_locked",  10'(locked), 10'd1);
        check("c354_word",    word,        10'h354);
        check("c354_ctrl",    10'(ctrl),   10'd1);
        check("c354_offset",  10'(offset), 10'd0);

        // Data only after lock: lock drops on the 32nd word after the lock word.
        for (n = 10; n <= 41; n++) begin
            emit_call(DATA_SYM);
            if (n == 10) check("loss_ctrl_w10",   10'(ctrl),   10'd1);
            if (n == 40) check("loss_locked_w40", 10'(locked), 10'd1);
        end
        check("loss_locked_w41", 10'(locked), 10'd0);
        check("loss_offset",     10'(offset), 10'd0);
        check("loss_word",       word,        DATA_SYM);
        check("loss_ctrl",       10'(ctrl),   10'd0);

        // False start: five 0x154 then data returns to SEARCH without slipping.
        do_reset();
        for (n = 1; n <= 5; n++) emit_call(10'h154);
        emit_call(DATA_SYM);
        check("fs_word_w6",   word,        10'h154);
        check("fs_ctrl_w6",   10'(ctrl),   10'd1);
        check("fs_locked_w6", 10'(locked), 10'd0);
        emit_call(DATA_SYM);
        check("fs_ctrl_w7",   10'(ctrl),   10'd0);
        check("fs_locked_w7", 10'(locked), 10'd0);
        check("fs_offset_w7", 10'(offset), 10'd0);

        // The miss counter restarted on CHECK entry, so the first slip is 64 words later.
        for (n = 8; n <= 647; n++) begin
            emit_call(DATA_SYM);
            if (n == 70)  check("slip_off_w70",  10'(offset), 10'd0);
            if (n == 71)  check("slip_off_w71",  10'(offset), 10'd1);
            if (n == 583) check("slip_off_w583", 10'(offset), 10'd9);
            if (n == 646) check("slip_off_w646", 10'(offset), 10'd9);
        end
        check("slip_wrap_w647", 10'(offset), 10'd0);

        // Line of 16 control + 48 data words, delayed by 3 bits.
        do_reset();
        for (int i = 0; i < 3; i++) bq.push_back(1'b0);
        for (n = 1; n <= 64; n++) begin
            emit_call(line_sym(n - 1));
            if (n == 63) check("al_off_w63", 10'(offset), 10'd0);
        end
        check("al_off_w64", 10'(offset), 10'd1);
        n = 64;
        while (!locked && n < 400) begin
            n++;
            emit_call(line_sym(n - 1));
        end
        check("al_lock_word_index", 10'(n),      10'd201);
        check("al_locked",          10'(locked), 10'd1);
        check("al_offset",          10'(offset), 10'd3);
        for (n = 202; n <= 212; n++) begin
            emit_call(line_sym(n - 1));
            check($sformatf("al_word_w%0d", n),   word,        sent[n - 2]);
            check($sformatf("al_ctrl_w%0d", n),   10'(ctrl),   10'(exp_ctrl(sent[n - 2])));
            check($sformatf("al_locked_w%0d", n), 10'(locked), 10'd1);
        end

        // Asynchronous reset between edges while locked.
        check("ar_pre_valid", 10'(word_valid), 10'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_locked", 10'(locked),     10'd0);
        check("ar_valid",  10'(word_valid), 10'd0);
        check("ar_word",   word,            10'h000);
        check("ar_offset", 10'(offset),     10'd0);
        bq.delete();
        sent.delete();
        #3 rst_n = 1'b1;
        repeat (4) step();
        check("ar_strobe_edge4", 10'(word_valid), 10'd0);
        step();
        check("ar_strobe_edge5", 10'(word_valid), 10'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tmds_word_aligner.md
# tmds_word_aligner

Recovers 10-bit TMDS symbols from one HDMI data lane's input DDR sampler, two bits per `clk_shift` edge. Finds the symbol boundary by bit-slipping until a run of TMDS control symbols is seen. Emits aligned words with a one-cycle strobe every 5 shift clocks. One instance per lane sits directly downstream of each `IDDRX1F`, ahead of any TMDS decoder or re-serialiser.

## Interface
- `CTRL_RUN`, 8: consecutive control symbols required to declare lock.
- `SLIP_TIMEOUT`, 4096: words without any control symbol (SEARCH state) before bit slip; counter 13 bits.
- `LOSS_WORDS`, 8192: words without a full `CTRL_RUN` run (LOCKED state) before lock is dropped; counter 14 bits.
- `clk_shift`  in  1  bit clock (5x pixel clock, DDR); all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `q`  in  2  DDR sample pair; `q[0]` is the earlier bit in time.
- `word`  out  10  aligned symbol, bit 0 = first transmitted bit.
- `word_valid`  out  1  one-cycle strobe; `word` is valid while it is high.
- `ctrl`  out  1  qualifies `word_valid`; `word` is one of the four control symbols.
- `locked`  out  1  alignment achieved.
- `offset`  out  4  current bit offset, 0..9.

## Operation
- History register `hist[19:0]`, 20 bits. Each edge: `hist_next = {q[1], q[0], hist[19:2]}`. Newest bits go in at the top; older bits sit at lower indices.
- Phase counter `ph` runs 0..4 and wraps. On an edge with `ph==4`:
  - `word <= hist_next[offset+9 : offset]`
  - `word_valid <= 1`
  - `ctrl <= (that word ∈ {0x354, 0x0AB, 0x154, 0x2AB})`
- On every other edge, `word_valid <= 0`. `word` and `ctrl` hold.
- Internal signal `is_ctrl` is the same comparison as `ctrl`, taken on the word being emitted.
- FSM states are SEARCH, CHECK and LOCKED. Reset state is SEARCH. The FSM updates only on emit edges (`ph==4`).
- SEARCH:
  - `is_ctrl` → CHECK, with run=1 and miss=0.
  - Otherwise miss+1. When miss reaches `SLIP_TIMEOUT`: `offset` ← `(offset==9) ? 0 : offset+1`, and miss=0.
- CHECK:
  - `is_ctrl` → run+1. When run reaches `CTRL_RUN` → LOCKED, with `locked=1` and loss=0.
  - Non-control word → SEARCH, with run=0. `offset` and miss are unchanged; there is no slip.
- LOCKED:
  - Counts consecutive control symbols in run.
  - run reaching `CTRL_RUN` clears loss. A non-control word clears run.
  - loss increments on every emitted word. When loss reaches `LOSS_WORDS` → SEARCH, with `locked=0`. `offset` is kept.
- Simultaneous events:
  - A control symbol on the same word that hits `SLIP_TIMEOUT`: the control symbol wins, with no slip.
  - In LOCKED, run completing on the same word that loss expires: the run wins and lock is kept.
- An `offset` change takes effect on the next emitted word. `ph` is never disturbed by a slip.
- A run of `CTRL_RUN`=1 locks on the first control symbol, passing through CHECK in zero words.

## Timing
- Reset values: `hist`, `ph`, `word`, `offset` = 0; `word_valid`, `ctrl`, `locked` = 0; state SEARCH; all counters 0. The effect is immediate on `rst_n` low, without waiting for a clock.
- First `word_valid` comes on the 5th rising edge after `rst_n` deasserts.
- After that, `word_valid` is high exactly one cycle in every 5.
- Latency: the pair sampled on an emit edge is already inside `word` on that same edge. Outputs are registered, so they are visible one cycle after the last bit pair.
- `locked` rises on the emit edge of the `CTRL_RUN`-th control word. It falls on the emit edge where loss reaches `LOSS_WORDS`.
- Reset mid-operation: all state is discarded and search restarts at `offset`=0.

## Structure
- Shared package `tmds_pkg` holds:
  - constants `TMDS_CTRL_00=0x354`, `_01=0x0AB`, `_10=0x154`, `_11=0x2AB`
  - a function `is_tmds_ctrl(word)`
  - an FSM state enum `align_state_t`
  - the TMDS decoder reuses these.
- One natural sub-module is `tmds_bit_window`: the 20-bit history, the 0..9 barrel select and the mod-5 phase counter. The FSM stays in the top module.

## Test plan
- Continuous 0x354 at offset 0 → `locked`=1 on the 8th emitted word; `word`=0x354, `ctrl`=1, `offset`=0.
- Repeating line of 16 control words (0x354/0x0AB alternating) plus 48 data words (LFSR, no control patterns at any rotation), delayed by 3 bits, with `SLIP_TIMEOUT`=64 → `offset` settles at 3, `locked`=1, `word` matches the sent sequence.
- Aligned stream with 5 × 0x154 then data → state returns to SEARCH; `locked`=0, `offset` unchanged, no slip.
- Locked, then data only with `LOSS_WORDS`=32 → `locked` falls on exactly the 32nd word; `offset` is kept.
- Force `offset`=9 by timeouts, one more timeout → `offset`=0.
- `rst_n` pulsed low between clock edges while locked → `locked`, `word_valid`, `word`, `offset` all 0 immediately; first strobe comes 5 edges after release.
